rcp_rate_stamper: RTL
=====================

Name: rcp_rate_stamper

Overview:
Egress-side companion to the RCP header parser. It sits in the output path of the rcp_router user datapath, passes the NetFPGA packet stream through with one register stage, and rewrites the 32-bit RCP rate field with the router's locally computed fair rate whenever that rate is lower than the carried value. It also keeps per-block packet counters for the register interface.

Parameters:
DATA_WIDTH, 64, packet bus data width
CTRL_WIDTH, 8, packet bus control width
TYPE_WORD, 2, payload word index holding the IP protocol byte in in_data[7:0]
FRATE_WORD, 5, payload word index holding the RCP rate in in_data[47:16]; must be greater than TYPE_WORD
RCP_TYPE, 8'hFE, protocol value identifying RCP packets

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_WIDTH  packet data from previous stage
in_ctrl  in  CTRL_WIDTH  packet ctrl: 0xFF = module header, 0x00 = payload, other = last word byte-enable
in_wr  in  1  input word valid
in_rdy  out  1  block can accept a word
out_data  out  DATA_WIDTH  packet data to next stage
out_ctrl  out  CTRL_WIDTH  packet ctrl to next stage
out_wr  out  1  output word valid
out_rdy  in  1  next stage ready; nearly-full semantics with at least 1 word of slack
local_rate  in  32  locally computed fair rate, unsigned
local_rate_vld  in  1  one-cycle strobe; local_rate is valid
stamp_en  in  1  global enable for rewriting; 0 = pure pass-through
rcp_pkt_cnt  out  32  number of RCP packets seen
stamped_pkt_cnt  out  32  number of packets whose rate field was rewritten

Behaviour:
- Reset (async, active-high): out_data=0, out_ctrl=0, out_wr=0, both counters=0, state=IDLE, rate_have=0, shadow and active rate=0, is_rcp=0, word_idx=0.
- Handshake:
  - in_rdy = out_rdy (combinational).
  - A word is accepted when in_wr && in_rdy.
  - On an accepted word, out_data/out_ctrl register the (possibly modified) word and out_wr=1 on the next cycle; otherwise out_wr=0 on the next cycle.
  - Latency is exactly 1 cycle, with no bubbles inserted. out_ctrl always equals the input ctrl.
- Rate capture:
  - local_rate_vld loads the shadow register and sets rate_have=1.
  - Active rate loads from shadow on the first accepted 0xFF word in IDLE. If local_rate_vld occurs in that same cycle, active loads local_rate directly.
  - Active rate is never changed mid-packet.
- FSM (advances only on accepted words):
  - IDLE: on ctrl=0xFF -> HDR; is_rcp<=0; latch the active rate. A ctrl=0x00 word in IDLE passes unmodified and the state is unchanged.
  - HDR: on ctrl=0xFF stay in HDR. On ctrl=0x00 -> PAYLOAD; this word is word_idx 0; next word_idx=1.
  - PAYLOAD: each accepted word increments word_idx. word_idx saturates at FRATE_WORD+1 and is 4 bits wide minimum. Any ctrl other than 0x00 is the last word -> IDLE.
- Classification: at word_idx==TYPE_WORD, if in_data[7:0]==RCP_TYPE then is_rcp<=1 and rcp_pkt_cnt increments.
- Stamping: at word_idx==FRATE_WORD, the word is rewritten if all of the following hold:
  - is_rcp=1, stamp_en=1, rate_have=1
  - active rate < in_data[47:16] (unsigned compare)

  When rewritten, bits [47:16] are replaced by the active rate, all other bits are unchanged, and stamped_pkt_cnt increments. Equal rates are not rewritten.
- Boundaries:
  - A packet ending before FRATE_WORD is not stamped.
  - If the last word is exactly FRATE_WORD, it is still stamped when the conditions hold.
  - Counters wrap at 2^32.
  - stamp_en is sampled on the FRATE_WORD cycle itself.
  - Reset mid-packet drops the block to IDLE. The remaining words of that packet pass unmodified until the next 0xFF word.
  - While out_rdy=0, no state, counter or output register changes, except that out_wr goes to 0.

Test Plan:
- RCP packet (word2[7:0]=FE, word5 rate=0x0000_1000), local_rate=0x800 strobed beforehand, stamp_en=1 -> word5 out has [47:16]=0x0000_0800, all other bits and words bit-exact, 1-cycle latency, both counters=1.
- Same packet with local_rate=0x2000 -> forwarded unchanged; rcp_pkt_cnt=1, stamped_pkt_cnt=0. Repeat with local_rate=0x1000 -> unchanged.
- Non-RCP packet (word2[7:0]=0x06), local_rate=0x1 -> unchanged, both counters 0. 4-word RCP packet -> unchanged, rcp_pkt_cnt=1, stamped=0.
- local_rate_vld=0x100 pulsed at word 3 of packet A (current active rate 0x800, carried rate 0x1000) -> A stamped with 0x800; next packet B stamped with 0x100. Strobe coincident with B's first 0xFF word -> B uses the new value.
- out_rdy toggled 1/0 every cycle with in_wr held high across 3 back-to-back packets -> output sequence identical to the no-backpressure case; out_wr never asserted for a non-accepted word.
- No local_rate_vld since reset, RCP packet -> unchanged. Assert reset at word 4 of an RCP packet, release -> remaining words pass unmodified, counters 0; the following packet behaves normally.

Source files
------------

// File: rtl/rcp_rate_stamper.sv
// RCP egress rate stamper: a one-stage pass-through on the NetFPGA packet bus. It lowers the
// carried RCP rate field to the locally computed fair rate and counts RCP and stamped packets.
module rcp_rate_stamper #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned TYPE_WORD  = 2,
  parameter int unsigned FRATE_WORD = 5,
  parameter logic [7:0]  RCP_TYPE   = 8'hFE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [31:0]           local_rate,
  input  logic                  local_rate_vld,
  input  logic                  stamp_en,
  output logic [31:0]           rcp_pkt_cnt,
  output logic [31:0]           stamped_pkt_cnt
);

  localparam int unsigned IdxW =
      ($clog2(FRATE_WORD + 2) > 4) ? $clog2(FRATE_WORD + 2) : 4;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(FRATE_WORD + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       word_idx_q, word_idx_d, cur_idx;
  logic                  is_rcp_q, is_rcp_d;
  logic                  rate_have_q, rate_have_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           active_q, active_d;
  logic [31:0]           rcp_cnt_d, stamped_cnt_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  accept, ctrl_hdr, ctrl_pay, pay_word, type_hit, stamp_hit;

  assign in_rdy   = out_rdy;
  assign accept   = in_wr & out_rdy;
  assign ctrl_hdr = (in_ctrl == {CTRL_WIDTH{1'b1}});
  assign ctrl_pay = (in_ctrl == '0);

  // The word that moves HDR->PAYLOAD is payload index 0; later words use the running index.
  assign cur_idx  = (state_q == StHdr) ? '0 : word_idx_q;
  assign pay_word = ((state_q == StHdr) && ctrl_pay) || (state_q == StPayload);

  assign type_hit  = accept && pay_word && (cur_idx == IdxW'(TYPE_WORD)) &&
                     (in_data[7:0] == RCP_TYPE);
  assign stamp_hit = accept && pay_word && (cur_idx == IdxW'(FRATE_WORD)) &&
                     is_rcp_q && stamp_en && rate_have_q && (active_q < in_data[47:16]);

  // Next-state: packet FSM, classification, rate capture and word rewrite.
  always_comb begin
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    is_rcp_d      = is_rcp_q;
    rate_have_d   = rate_have_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    rcp_cnt_d     = rcp_pkt_cnt;
    stamped_cnt_d = stamped_pkt_cnt;
    data_d        = in_data;

    if (type_hit) begin
      is_rcp_d  = 1'b1;
      rcp_cnt_d = rcp_pkt_cnt + 32'd1;
    end
    if (stamp_hit) begin
      data_d[47:16] = active_q;
      stamped_cnt_d = stamped_pkt_cnt + 32'd1;
    end
    // The shadow tracks the strobe at any time; the active rate only moves at packet start.
    if (local_rate_vld) begin
      shadow_d    = local_rate;
      rate_have_d = 1'b1;
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_hdr) begin
            state_d  = StHdr;
            is_rcp_d = 1'b0;
            active_d = local_rate_vld ? local_rate : shadow_q;
          end
        end
        StHdr: begin
          if (ctrl_pay) begin
            state_d    = StPayload;
            word_idx_d = IdxW'(1);
          end
        end
        StPayload: begin
          if (word_idx_q != IdxMax) word_idx_d = word_idx_q + IdxW'(1);
          if (!ctrl_pay) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counter and output registers; the output stage only loads on an accepted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      word_idx_q      <= '0;
      is_rcp_q        <= 1'b0;
      rate_have_q     <= 1'b0;
      shadow_q        <= '0;
      active_q        <= '0;
      rcp_pkt_cnt     <= '0;
      stamped_pkt_cnt <= '0;
      out_data        <= '0;
      out_ctrl        <= '0;
      out_wr          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_idx_q      <= word_idx_d;
      is_rcp_q        <= is_rcp_d;
      rate_have_q     <= rate_have_d;
      shadow_q        <= shadow_d;
      active_q        <= active_d;
      rcp_pkt_cnt     <= rcp_cnt_d;
      stamped_pkt_cnt <= stamped_cnt_d;
      out_wr          <= accept;
      if (accept) begin
        out_data <= data_d;
        out_ctrl <= in_ctrl;
      end
    end
  end

endmodule
